// File: rtl/game_state_ctrl_pkg.sv
// Shared encodings and widths for the game round controller and its neighbours.
package game_state_ctrl_pkg;

  localparam int unsigned c_GAME_HEIGHT = 480;
  localparam int unsigned c_GAME_WIDTH  = 640;
  localparam int unsigned c_TILE        = 32;

  localparam int unsigned c_Y_W     = 10;
  localparam int unsigned c_LIVES_W = 3;
  localparam int unsigned c_LEVEL_W = 4;
  localparam int unsigned c_SCORE_W = 8;
  localparam int unsigned c_FCNT_W  = 7;
  localparam int unsigned c_STATE_W = 3;

  typedef enum logic [c_STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } game_state_e;

endpackage

// File: rtl/game_state_ctrl_frame_delay_ctr.sv
// Loadable frame counter used to time the HIT and WIN freeze periods.
module frame_delay_ctr
  import game_state_ctrl_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Load,
  input  logic                i_En,
  input  logic                i_Frame_Start,
  input  logic [c_FCNT_W-1:0] i_Target,
  output logic                o_Done_c
);

  logic [c_FCNT_W-1:0] count_q;
  logic [c_FCNT_W-1:0] count_d;

  // Clear on load, otherwise count frames up to the target and hold there.
  always_comb begin
    count_d = count_q;
    if (i_Load) begin
      count_d = '0;
    end else if (i_En && i_Frame_Start && (count_q != i_Target)) begin
      count_d = count_q + c_FCNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Done_c = (count_q == i_Target);

endmodule

// File: rtl/game_state_ctrl.sv
// Round-level game controller: collision, goal, lives, level, score and freeze.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int unsigned c_START_LIVES = 3,
  parameter int unsigned c_MAX_LEVEL   = 9,
  parameter int unsigned c_HIT_FRAMES  = 60,
  parameter int unsigned c_WIN_FRAMES  = 30
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Start,
  input  logic                 i_Frame_Start,
  input  logic                 i_Draw_Player,
  input  logic                 i_Draw_Obstacle,
  input  logic [c_Y_W-1:0]     i_Player_Y,
  output logic                 o_Player_Reset,
  output logic                 o_Freeze,
  output logic                 o_Game_Active,
  output logic                 o_Game_Over,
  output logic [c_LIVES_W-1:0] o_Lives,
  output logic [c_LEVEL_W-1:0] o_Level,
  output logic [c_SCORE_W-1:0] o_Score,
  output logic [c_STATE_W-1:0] o_State
);

  localparam logic [c_LIVES_W-1:0] c_LIVES_INIT = c_LIVES_W'(c_START_LIVES);
  localparam logic [c_LEVEL_W-1:0] c_LEVEL_MAX  = c_LEVEL_W'(c_MAX_LEVEL);
  localparam logic [c_FCNT_W-1:0]  c_HIT_TGT    = c_FCNT_W'(c_HIT_FRAMES);
  localparam logic [c_FCNT_W-1:0]  c_WIN_TGT    = c_FCNT_W'(c_WIN_FRAMES);
  localparam logic [c_SCORE_W-1:0] c_SCORE_MAX  = '1;

  game_state_e          state_q, state_d;
  logic [c_LIVES_W-1:0] lives_q, lives_d;
  logic [c_LEVEL_W-1:0] level_q, level_d;
  logic [c_SCORE_W-1:0] score_q, score_d;
  logic                 player_reset_q, player_reset_d;
  logic                 freeze_q, freeze_d;
  logic                 game_active_q, game_active_d;
  logic                 game_over_q, game_over_d;
  logic                 start_q, start_d;
  logic                 hit_latch_q, hit_latch_d;

  logic                 start_evt_c;
  logic                 overlap_c;
  logic                 hit_c;
  logic                 ctr_load_c;
  logic                 ctr_en_c;
  logic                 ctr_done_c;
  logic [c_FCNT_W-1:0]  ctr_target_c;

  // Freeze-period timer shared by HIT and WIN; target follows the current state.
  frame_delay_ctr u_frame_delay_ctr (
    .i_Clk         (i_Clk),
    .i_Rst_n       (i_Rst_n),
    .i_Load        (ctr_load_c),
    .i_En          (ctr_en_c),
    .i_Frame_Start (i_Frame_Start),
    .i_Target      (ctr_target_c),
    .o_Done_c      (ctr_done_c)
  );

  assign start_evt_c  = i_Start & ~start_q;
  assign overlap_c    = i_Draw_Player & i_Draw_Obstacle;
  assign hit_c        = hit_latch_q | overlap_c;
  assign ctr_en_c     = (state_q == S_HIT) || (state_q == S_WIN);
  assign ctr_target_c = (state_q == S_WIN) ? c_WIN_TGT : c_HIT_TGT;

  // Next state, round bookkeeping and registered output values.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    level_d        = level_q;
    score_d        = score_q;
    player_reset_d = 1'b0;
    start_d        = i_Start;
    hit_latch_d    = 1'b0;
    ctr_load_c     = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_evt_c) begin
          lives_d        = c_LIVES_INIT;
          level_d        = c_LEVEL_W'(1);
          score_d        = '0;
          player_reset_d = 1'b1;
          state_d        = S_PLAY;
        end
      end
      S_PLAY: begin
        if (i_Frame_Start) begin
          // A collision anywhere in the frame beats reaching the goal row.
          if (hit_c) begin
            lives_d    = lives_q - c_LIVES_W'(1);
            ctr_load_c = 1'b1;
            state_d    = S_HIT;
          end else if (i_Player_Y == '0) begin
            score_d    = (score_q == c_SCORE_MAX) ? score_q : score_q + c_SCORE_W'(1);
            level_d    = (level_q == c_LEVEL_MAX) ? level_q : level_q + c_LEVEL_W'(1);
            ctr_load_c = 1'b1;
            state_d    = S_WIN;
          end
        end else begin
          hit_latch_d = hit_latch_q | overlap_c;
        end
      end
      S_HIT: begin
        if (ctr_done_c) begin
          if (lives_q == '0) begin
            state_d = S_OVER;
          end else begin
            player_reset_d = 1'b1;
            state_d        = S_PLAY;
          end
        end
      end
      S_WIN: begin
        if (ctr_done_c) begin
          player_reset_d = 1'b1;
          state_d        = S_PLAY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    freeze_d      = (state_d != S_PLAY);
    game_active_d = (state_d == S_PLAY) || (state_d == S_HIT) || (state_d == S_WIN);
    game_over_d   = (state_d == S_OVER);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q        <= S_IDLE;
      lives_q        <= c_LIVES_INIT;
      level_q        <= c_LEVEL_W'(1);
      score_q        <= '0;
      player_reset_q <= 1'b0;
      freeze_q       <= 1'b1;
      game_active_q  <= 1'b0;
      game_over_q    <= 1'b0;
      start_q        <= 1'b0;
      hit_latch_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      score_q        <= score_d;
      player_reset_q <= player_reset_d;
      freeze_q       <= freeze_d;
      game_active_q  <= game_active_d;
      game_over_q    <= game_over_d;
      start_q        <= start_d;
      hit_latch_q    <= hit_latch_d;
    end
  end

  assign o_Player_Reset = player_reset_q;
  assign o_Freeze       = freeze_q;
  assign o_Game_Active  = game_active_q;
  assign o_Game_Over    = game_over_q;
  assign o_Lives        = lives_q;
  assign o_Level        = level_q;
  assign o_Score        = score_q;
  assign o_State        = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: start, hit, win, game over, level saturation, reset.
module tb_game_state_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n;
  logic       i_Start;
  logic       i_Frame_Start;
  logic       i_Draw_Player;
  logic       i_Draw_Obstacle;
  logic [9:0] i_Player_Y;
  logic       o_Player_Reset;
  logic       o_Freeze;
  logic       o_Game_Active;
  logic       o_Game_Over;
  logic [2:0] o_Lives;
  logic [3:0] o_Level;
  logic [7:0] o_Score;
  logic [2:0] o_State;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PLAY = 3'd1;
  localparam logic [2:0] ST_HIT  = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_OVER = 3'd4;

  game_state_ctrl dut (
    .i_Clk           (i_Clk),
    .i_Rst_n         (i_Rst_n),
    .i_Start         (i_Start),
    .i_Frame_Start   (i_Frame_Start),
    .i_Draw_Player   (i_Draw_Player),
    .i_Draw_Obstacle (i_Draw_Obstacle),
    .i_Player_Y      (i_Player_Y),
    .o_Player_Reset  (o_Player_Reset),
    .o_Freeze        (o_Freeze),
    .o_Game_Active   (o_Game_Active),
    .o_Game_Over     (o_Game_Over),
    .o_Lives         (o_Lives),
    .o_Level         (o_Level),
    .o_Score         (o_Score),
    .o_State         (o_State)
  );

  always #20 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; returns at the following falling edge with outputs settled.
  task automatic tick();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  task automatic frame();
    i_Frame_Start = 1'b1;
    tick();
    i_Frame_Start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic overlap_pixel();
    i_Draw_Player   = 1'b1;
    i_Draw_Obstacle = 1'b1;
    tick();
    i_Draw_Player   = 1'b0;
    i_Draw_Obstacle = 1'b0;
  endtask

  int pulses;

  initial begin
    i_Rst_n         = 1'b0;
    i_Start         = 1'b0;
    i_Frame_Start   = 1'b0;
    i_Draw_Player   = 1'b0;
    i_Draw_Obstacle = 1'b0;
    i_Player_Y      = 10'd448;
    @(negedge i_Clk);

    // Reset state
    tick();
    tick();
    i_Rst_n = 1'b1;
    check("rst_state",  32'(o_State), 32'(ST_IDLE));
    check("rst_lives",  32'(o_Lives), 32'd3);
    check("rst_level",  32'(o_Level), 32'd1);
    check("rst_score",  32'(o_Score), 32'd0);
    check("rst_freeze", 32'(o_Freeze), 32'd1);
    check("rst_preset", 32'(o_Player_Reset), 32'd0);
    check("rst_active", 32'(o_Game_Active), 32'd0);
    check("rst_over",   32'(o_Game_Over), 32'd0);

    // Start held for 100 cycles gives exactly one reset pulse
    i_Start = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_Player_Reset) pulses++;
      if (i == 0) check("start_pulse_first", 32'(o_Player_Reset), 32'd1);
    end
    i_Start = 1'b0;
    check("start_pulses", 32'(pulses), 32'd1);
    check("start_state",  32'(o_State), 32'(ST_PLAY));
    check("start_freeze", 32'(o_Freeze), 32'd0);
    check("start_active", 32'(o_Game_Active), 32'd1);

    // Start ignored in PLAY; a clean frame stays in PLAY
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    check("play_start_ign_state", 32'(o_State), 32'(ST_PLAY));
    check("play_start_ign_prst",  32'(o_Player_Reset), 32'd0);
    frame();
    check("clean_frame_state", 32'(o_State), 32'(ST_PLAY));
    check("clean_frame_lives", 32'(o_Lives), 32'd3);

    // Mid-frame overlap latched, acted on at the next frame start
    tick();
    overlap_pixel();
    tick();
    check("latch_wait_state", 32'(o_State), 32'(ST_PLAY));
    frame();
    check("hit1_state",  32'(o_State), 32'(ST_HIT));
    check("hit1_lives",  32'(o_Lives), 32'd2);
    check("hit1_freeze", 32'(o_Freeze), 32'd1);
    frames(59);
    check("hit1_59_state", 32'(o_State), 32'(ST_HIT));
    frame();
    check("hit1_60_state", 32'(o_State), 32'(ST_HIT));
    tick();
    check("hit1_ret_state", 32'(o_State), 32'(ST_PLAY));
    check("hit1_ret_prst",  32'(o_Player_Reset), 32'd1);
    tick();
    check("hit1_ret_prst_off", 32'(o_Player_Reset), 32'd0);

    // Goal row reached without overlap
    i_Player_Y = 10'd0;
    frame();
    i_Player_Y = 10'd448;
    check("win_state", 32'(o_State), 32'(ST_WIN));
    check("win_score", 32'(o_Score), 32'd1);
    check("win_level", 32'(o_Level), 32'd2);
    frames(29);
    check("win_29_state", 32'(o_State), 32'(ST_WIN));
    frame();
    tick();
    check("win_ret_state", 32'(o_State), 32'(ST_PLAY));
    check("win_ret_prst",  32'(o_Player_Reset), 32'd1);
    tick();

    // Goal row and overlap in the same frame: hit wins
    i_Player_Y = 10'd0;
    overlap_pixel();
    frame();
    i_Player_Y = 10'd448;
    check("both_state", 32'(o_State), 32'(ST_HIT));
    check("both_lives", 32'(o_Lives), 32'd1);
    check("both_score", 32'(o_Score), 32'd1);
    check("both_level", 32'(o_Level), 32'd2);
    frames(60);
    tick();
    check("both_ret_state", 32'(o_State), 32'(ST_PLAY));
    tick();

    // Last life lost with overlap only on the frame-start cycle
    i_Draw_Player   = 1'b1;
    i_Draw_Obstacle = 1'b1;
    frame();
    i_Draw_Player   = 1'b0;
    i_Draw_Obstacle = 1'b0;
    check("hit3_state", 32'(o_State), 32'(ST_HIT));
    check("hit3_lives", 32'(o_Lives), 32'd0);
    frames(60);
    tick();
    check("over_state",  32'(o_State), 32'(ST_OVER));
    check("over_flag",   32'(o_Game_Over), 32'd1);
    check("over_prst",   32'(o_Player_Reset), 32'd0);
    check("over_active", 32'(o_Game_Active), 32'd0);
    check("over_freeze", 32'(o_Freeze), 32'd1);
    check("over_score",  32'(o_Score), 32'd1);
    check("over_level",  32'(o_Level), 32'd2);

    // Restart from OVER
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    check("restart_state", 32'(o_State), 32'(ST_PLAY));
    check("restart_prst",  32'(o_Player_Reset), 32'd1);
    check("restart_lives", 32'(o_Lives), 32'd3);
    check("restart_score", 32'(o_Score), 32'd0);
    check("restart_level", 32'(o_Level), 32'd1);
    check("restart_over",  32'(o_Game_Over), 32'd0);
    tick();

    // Nine goal crossings: level saturates at 9, score counts to 9
    for (int w = 0; w < 9; w++) begin
      i_Player_Y = 10'd0;
      frame();
      i_Player_Y = 10'd448;
      frames(30);
      tick();
      tick();
    end
    check("sat_state", 32'(o_State), 32'(ST_PLAY));
    check("sat_level", 32'(o_Level), 32'd9);
    check("sat_score", 32'(o_Score), 32'd9);

    // Reset asserted mid-HIT returns to IDLE after one edge
    overlap_pixel();
    frame();
    check("pre_rst_state", 32'(o_State), 32'(ST_HIT));
    frames(5);
    i_Rst_n = 1'b0;
    tick();
    check("midrst_state",  32'(o_State), 32'(ST_IDLE));
    check("midrst_lives",  32'(o_Lives), 32'd3);
    check("midrst_level",  32'(o_Level), 32'd1);
    check("midrst_score",  32'(o_Score), 32'd0);
    check("midrst_freeze", 32'(o_Freeze), 32'd1);
    check("midrst_active", 32'(o_Game_Active), 32'd0);
    i_Rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
